// File: rtl/regfile_pkg.sv
// Shared register-file types and sizing used by the issue scoreboard and the
// write-back queue it shadows.
package regfile_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t XZR      = 5'd31;
    localparam int       NREGS    = 32;
    localparam int       WB_DEPTH = 4;
    // Counter width; 2**CW must exceed WB_DEPTH so a full register never wraps.
    localparam int       CW       = 3;

endpackage

// File: rtl/scoreboard_counter.sv
// Per-register pending-write counter: counts up on issue, down on retire,
// and flags a retire that arrives while the count is already zero.
module scoreboard_counter
    import regfile_pkg::*;
#(
    parameter int W = CW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         nonzero,
    output logic         underflow
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        cnt_d     = cnt_q;
        underflow = 1'b0;
        case ({inc, dec})
            2'b10: cnt_d = cnt_q + W'(1);
            2'b01: begin
                if (cnt_q == '0) underflow = 1'b1;
                else             cnt_d     = cnt_q - W'(1);
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    // Still pending once this cycle's retire has landed in the register file.
    assign nonzero = (cnt_q - W'(dec)) != '0;

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-stage scoreboard: stalls on RAW hazards against in-flight writes and
// when the write-back queue is already holding WB_DEPTH tracked writes.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic          issue_wr,
    input  reg_idx_t      issue_rd,
    input  reg_idx_t      rs_a,
    input  reg_idx_t      rs_b,
    input  logic          rs_a_used,
    input  logic          rs_b_used,
    input  logic          retire_wr,
    input  reg_idx_t      retire_rd,
    output logic          stall,
    output logic [CW-1:0] inflight_cnt,
    output logic          err_underflow
);

    logic [NREGS-1:0] inc_vec, ret_vec, nz_vec, uf_vec;
    logic [CW-1:0]    cnt_arr [NREGS];
    logic [CW-1:0]    inflight_q, inflight_d;
    logic             err_q, err_d;
    logic             ret_any, ret_eff, raw, full, accept, inc_any;

    // XZR has no counter; its slot reads as permanently idle.
    assign nz_vec[XZR]  = 1'b0;
    assign uf_vec[XZR]  = 1'b0;
    assign cnt_arr[XZR] = '0;

    for (genvar r = 0; r < NREGS - 1; r++) begin : g_cnt
        scoreboard_counter #(.W(CW)) u_cnt (
            .clk      (clk),
            .rst_n    (reset),
            .inc      (inc_vec[r]),
            .dec      (ret_vec[r]),
            .cnt      (cnt_arr[r]),
            .nonzero  (nz_vec[r]),
            .underflow(uf_vec[r])
        );
    end

    always_comb begin
        ret_any = retire_wr && (retire_rd != XZR);
        raw     = (rs_a_used && (rs_a != XZR) && nz_vec[rs_a])
               || (rs_b_used && (rs_b != XZR) && nz_vec[rs_b]);
        // A retire this cycle frees a queue slot for the incoming write.
        full    = issue_wr && (issue_rd != XZR)
               && ((inflight_q - CW'(ret_any)) == CW'(WB_DEPTH));
        stall   = issue_valid && (raw || full);
        accept  = issue_valid && !stall;
        inc_any = accept && issue_wr && (issue_rd != XZR);

        for (int r = 0; r < NREGS; r++) begin
            inc_vec[r] = inc_any && (issue_rd == reg_idx_t'(r));
            ret_vec[r] = ret_any && (retire_rd == reg_idx_t'(r));
        end

        // A retire against an empty counter leaves every count untouched.
        ret_eff    = ret_any && ((cnt_arr[retire_rd] != '0) || inc_vec[retire_rd]);
        inflight_d = inflight_q + CW'(inc_any) - CW'(ret_eff);
        err_d      = err_q || (|uf_vec);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight_cnt  = inflight_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard paired with a behavioural stand-in
// for regfilewrite_queue; expected values are hand-derived per cycle.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid, issue_wr, rs_a_used, rs_b_used;
    reg_idx_t      issue_rd, rs_a, rs_b;
    logic          retire_wr;
    reg_idx_t      retire_rd;
    logic          stall;
    logic [CW-1:0] inflight_cnt;
    logic          err_underflow;

    // Direct retire override, used to inject a stray retire.
    logic          ovr;
    logic          ovr_wr;
    reg_idx_t      ovr_rd;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic     wr;
        reg_idx_t rd;
    } wb_t;

    // Queue stand-in: a write accepted in cycle t is presented on RegWrtO in cycle t+5.
    wb_t pipe [5];

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 5; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{wr: issue_valid & ~stall & issue_wr, rd: issue_rd};
            for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign retire_wr = ovr ? ovr_wr : pipe[4].wr;
    assign retire_rd = ovr ? ovr_rd : pipe[4].rd;

    regfile_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_wr     (issue_wr),
        .issue_rd     (issue_rd),
        .rs_a         (rs_a),
        .rs_b         (rs_b),
        .rs_a_used    (rs_a_used),
        .rs_b_used    (rs_b_used),
        .retire_wr    (retire_wr),
        .retire_rd    (retire_rd),
        .stall        (stall),
        .inflight_cnt (inflight_cnt),
        .err_underflow(err_underflow)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input reg_idx_t rd,
                         input reg_idx_t a, input logic au);
        issue_valid = v;
        issue_wr    = w;
        issue_rd    = rd;
        rs_a        = a;
        rs_a_used   = au;
        rs_b        = 5'd0;
        rs_b_used   = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        repeat (n) next_cycle();
    endtask

    initial begin
        ovr    = 1'b0;
        ovr_wr = 1'b0;
        ovr_rd = 5'd0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",    stall,         0);
        check("rst_inflight", inflight_cnt,  0);
        check("rst_err",      err_underflow, 0);
        reset = 1'b1;
        next_cycle();

        // 1: write X5 then an immediate dependent read.
        drive(1'b1, 1'b1, 5'd5, 5'd0, 1'b0);
        check("t1_issue_stall", stall, 0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 5'd5, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t1_raw_stall_c%0d", i), stall, 1);
            if (i == 1) check("t1_inflight_1", inflight_cnt, 1);
            next_cycle();
        end
        check("t1_retire_cycle_stall", stall, 0);
        check("t1_retire_cycle_inflight", inflight_cnt, 1);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("t1_inflight_0", inflight_cnt, 0);

        // 2: XZR writes and reads are invisible.
        drive(1'b1, 1'b1, XZR, 5'd0, 1'b0);
        check("t2_wr31_stall", stall, 0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, XZR, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_rd31_stall_c%0d", i), stall, 0);
            check($sformatf("t2_inflight_c%0d", i), inflight_cnt, 0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("t2_err", err_underflow, 0);
        idle(2);

        // 3: fill the queue, fifth write waits for the first retire.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, reg_idx_t'(k), 5'd0, 1'b0);
            check($sformatf("t3_fill_stall_x%0d", k), stall, 0);
            next_cycle();
        end
        drive(1'b1, 1'b1, 5'd6, 5'd0, 1'b0);
        check("t3_full_stall", stall, 1);
        check("t3_full_inflight", inflight_cnt, 4);
        next_cycle();
        check("t3_x1_retire_accept", stall, 0);
        check("t3_x1_retire_inflight", inflight_cnt, 4);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("t3_after_accept_inflight", inflight_cnt, 4);
        idle(6);
        check("t3_drained", inflight_cnt, 0);

        // 4: WAW on X7, reader waits for the later write.
        drive(1'b1, 1'b1, 5'd7, 5'd0, 1'b0);
        check("t4_w1_stall", stall, 0);
        next_cycle();
        drive(1'b1, 1'b1, 5'd7, 5'd0, 1'b0);
        check("t4_w2_stall", stall, 0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 5'd7, 1'b1);
        check("t4_cnt2_inflight", inflight_cnt, 2);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("t4_raw_stall_c%0d", i), stall, 1);
            next_cycle();
        end
        check("t4_second_retire_stall", stall, 0);
        check("t4_second_retire_inflight", inflight_cnt, 1);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("t4_drained", inflight_cnt, 0);
        idle(2);

        // 5: stray retire of X9.
        ovr    = 1'b1;
        ovr_wr = 1'b1;
        ovr_rd = 5'd9;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("t5_err_before_edge", err_underflow, 0);
        next_cycle();
        ovr = 1'b0;
        drive(1'b1, 1'b0, 5'd0, 5'd9, 1'b1);
        check("t5_err_set", err_underflow, 1);
        check("t5_inflight", inflight_cnt, 0);
        check("t5_x9_read_stall", stall, 0);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        next_cycle();
        check("t5_err_sticky", err_underflow, 1);

        // 6: asynchronous reset with three writes outstanding.
        for (int k = 10; k <= 12; k++) begin
            drive(1'b1, 1'b1, reg_idx_t'(k), 5'd0, 1'b0);
            next_cycle();
        end
        drive(1'b1, 1'b0, 5'd0, 5'd10, 1'b1);
        check("t6_pre_stall", stall, 1);
        check("t6_pre_inflight", inflight_cnt, 3);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_inflight", inflight_cnt, 0);
        check("t6_async_stall", stall, 0);
        check("t6_async_err", err_underflow, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
